// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte-wide transmit buffer between the CPU register interface
//               and a UART serializer. Register writes push bytes into a
//               circular buffer that drains over a valid/ready handshake.
//               Provides status (empty/full/sticky overflow/count) and an
//               optional level interrupt at or below a low-water mark.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned LOW_WATER = 0
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       cs_i,
    input  logic       wr_i,
    input  logic [2:0] addr_i,
    input  logic [7:0] in_data_i,
    output logic [7:0] out_data_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       irq_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
    logic             we_q;

    logic w_we, w_commit, w_wr_ctrl, w_wr_tx, w_flush;
    logic w_empty, w_full, w_pop, w_push, w_ovf_set;

    // Strobe edge detection and decode of the committed operation.
    always_comb begin
        w_we      = ~cs_i & ~wr_i;
        w_commit  = w_we & ~we_q;
        w_wr_ctrl = w_commit & (addr_i == 3'd0);
        w_wr_tx   = w_commit & (addr_i == 3'd2);
        w_flush   = w_wr_ctrl & in_data_i[4];
        w_empty   = (count_q == '0);
        w_full    = (count_q == CNT_W'(DEPTH));
        // A flush wins over a same-cycle pop.
        w_pop     = ~w_empty & tx_ready_i & ~w_flush;
        // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
        w_push    = w_wr_tx & (~w_full | w_pop);
        w_ovf_set = w_wr_tx & w_full & ~w_pop;
    end

    // Next-state computation for pointers, count, flags and interrupt.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        irq_en_d   = irq_en_q;
        if (w_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        if (w_ovf_set) begin
            overflow_d = 1'b1;
        end else if (w_wr_ctrl & in_data_i[2]) begin
            overflow_d = 1'b0;
        end
        if (w_wr_ctrl) begin
            irq_en_d = in_data_i[3];
        end
        // Interrupt follows the post-update count and enable.
        irq_d = irq_en_d & (32'(count_d) <= LOW_WATER);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            we_q       <= w_we;
        end
    end

    // Buffer storage; contents are not reset, only the pointers are.
    always_ff @(posedge clock_i) begin
        if (reset_i && w_push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    // Register read mux and serializer-facing outputs.
    always_comb begin
        out_data_o = 8'h00;
        if (!cs_i) begin
            case (addr_i)
                3'd0:    out_data_o = {4'b0000, irq_en_q, overflow_q, w_full, w_empty};
                3'd1:    out_data_o = 8'(count_q);
                default: out_data_o = 8'h00;
            endcase
        end
        tx_valid_o = ~w_empty;
        tx_data_o  = w_empty ? 8'h00 : mem_q[rd_ptr_q];
        irq_o      = irq_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo: table-driven vectors,
//               directed corner-case sequences and randomized traffic checked
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH     = 16;
    localparam int LOW_WATER = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cs  = 1'b1;
    logic       wr  = 1'b1;
    logic [2:0] addr = 3'd0;
    logic [7:0] din  = 8'h00;
    logic       rdy  = 1'b0;
    logic [7:0] out_data, tx_data;
    logic       tx_valid, irq;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0] m_q[$];
    logic       m_ov = 1'b0, m_en = 1'b0, m_irq = 1'b0, m_we = 1'b0;

    uart_tx_fifo #(.DEPTH(DEPTH), .LOW_WATER(LOW_WATER)) dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .cs_i       (cs),
        .wr_i       (wr),
        .addr_i     (addr),
        .in_data_i  (din),
        .out_data_o (out_data),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (rdy),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%02h expected=%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock edge, updating the model from the inputs present before it.
    task automatic tick();
        logic we, commit, full, pop, flush;
        logic [7:0] tmp;
        we     = !cs && !wr;
        commit = we && !m_we;
        if (!rst) begin
            m_q.delete();
            m_ov = 1'b0; m_en = 1'b0; m_irq = 1'b0; m_we = 1'b0;
        end else begin
            pop   = (m_q.size() != 0) && rdy;
            flush = commit && (addr == 3'd0) && din[4];
            full  = (m_q.size() == DEPTH);
            if (flush) begin
                m_q.delete();
            end else begin
                if (pop) tmp = m_q.pop_front();
                if (commit && addr == 3'd2) begin
                    if (!full || pop) m_q.push_back(din);
                    else m_ov = 1'b1;
                end
            end
            if (commit && addr == 3'd0) begin
                if (din[2]) m_ov = 1'b0;
                m_en = din[3];
            end
            m_irq = m_en && (m_q.size() <= LOW_WATER);
            m_we  = we;
        end
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the model.
    task automatic check_all();
        logic [7:0] e_out;
        e_out = 8'h00;
        if (!cs) begin
            if (addr == 3'd0)
                e_out = {4'b0, m_en, m_ov, (m_q.size() == DEPTH), (m_q.size() == 0)};
            else if (addr == 3'd1)
                e_out = 8'(m_q.size());
        end
        check("model_out_data", out_data, e_out);
        check("model_tx_valid", {7'b0, tx_valid}, {7'b0, (m_q.size() != 0)});
        check("model_tx_data", tx_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
        check("model_irq", {7'b0, irq}, {7'b0, m_irq});
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b0; wr = 1'b0; addr = a; din = d;
        tick(); check_all();
        cs = 1'b1; wr = 1'b1;
        tick(); check_all();
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string name);
        cs = 1'b0; wr = 1'b1; addr = a;
        #1;
        check(name, out_data, exp);
        cs = 1'b1;
    endtask

    typedef struct packed {
        logic       rst;
        logic       cs;
        logic       wr;
        logic [2:0] addr;
        logic [7:0] din;
        logic       rdy;
        logic [7:0] e_out;
        logic       e_v;
        logic [7:0] e_d;
        logic       e_irq;
    } vec_t;

    vec_t vt [0:18];

    initial begin
        //          rst   cs    wr    addr  din    rdy   e_out  e_v   e_d    e_irq
        vt[0]  = '{1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 3'd2, 8'h41, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 3'd2, 8'h41, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 3'd2, 8'h42, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 3'd2, 8'h42, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 3'd2, 8'h43, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 8'h03, 1'b1, 8'h41, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h42, 1'b0};
        vt[10] = '{1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h43, 1'b0};
        vt[11] = '{1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[12] = '{1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0};
        vt[13] = '{1'b1, 1'b0, 1'b0, 3'd2, 8'h55, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0};
        vt[14] = '{1'b1, 1'b0, 1'b0, 3'd2, 8'h55, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0};
        vt[15] = '{1'b1, 1'b0, 1'b0, 3'd2, 8'h55, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0};
        vt[16] = '{1'b1, 1'b0, 1'b0, 3'd2, 8'h55, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0};
        vt[17] = '{1'b1, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 8'h01, 1'b1, 8'h55, 1'b0};
        vt[18] = '{1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};

        // Table: reset, basic push/drain, held strobe yields a single push.
        for (int i = 0; i < 19; i++) begin
            rst = vt[i].rst; cs = vt[i].cs; wr = vt[i].wr;
            addr = vt[i].addr; din = vt[i].din; rdy = vt[i].rdy;
            tick();
            check($sformatf("vec%0d_out_data", i), out_data, vt[i].e_out);
            check($sformatf("vec%0d_tx_valid", i), {7'b0, tx_valid}, {7'b0, vt[i].e_v});
            check($sformatf("vec%0d_tx_data", i), tx_data, vt[i].e_d);
            check($sformatf("vec%0d_irq", i), {7'b0, irq}, {7'b0, vt[i].e_irq});
            check_all();
        end
        rdy = 1'b0; cs = 1'b1; wr = 1'b1;
        tick(); check_all();

        // Fill to full, overflow, wrap-around drain, overflow clear.
        for (int i = 0; i < 16; i++) wr_reg(3'd2, 8'(i));
        rd(3'd0, 8'h02, "full_status");
        rd(3'd1, 8'h10, "full_count");
        wr_reg(3'd2, 8'hAA);
        rd(3'd0, 8'h06, "ovf_status");
        rd(3'd1, 8'h10, "ovf_count");
        rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_seq", tx_data, 8'(i));
            tick(); check_all();
        end
        rdy = 1'b0;
        check("drain_empty_valid", {7'b0, tx_valid}, 8'h00);
        wr_reg(3'd0, 8'h04);
        rd(3'd0, 8'h01, "ovf_cleared");

        // Push into a full FIFO in the same cycle as a pop.
        for (int i = 0; i < 16; i++) wr_reg(3'd2, 8'(8'h10 + i));
        cs = 1'b0; wr = 1'b0; addr = 3'd2; din = 8'hBB; rdy = 1'b1;
        tick(); check_all();
        cs = 1'b1; wr = 1'b1; rdy = 1'b0;
        tick(); check_all();
        rd(3'd1, 8'h10, "fullpop_count");
        rd(3'd0, 8'h02, "fullpop_status");
        rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("fullpop_seq", tx_data, (i < 15) ? 8'(8'h11 + i) : 8'hBB);
            tick(); check_all();
        end
        rdy = 1'b0;

        // Interrupt, flush and reset mid-drain.
        wr_reg(3'd0, 8'h08);
        wr_reg(3'd2, 8'h01);
        wr_reg(3'd2, 8'h02);
        check("irq_two_queued", {7'b0, irq}, 8'h00);
        rdy = 1'b1;
        tick(); check_all();
        check("irq_one_left", {7'b0, irq}, 8'h00);
        tick(); check_all();
        rdy = 1'b0;
        check("irq_after_last_pop", {7'b0, irq}, 8'h01);
        for (int i = 0; i < 5; i++) wr_reg(3'd2, 8'(8'h60 + i));
        wr_reg(3'd0, 8'h18);
        rd(3'd1, 8'h00, "flush_count");
        check("flush_valid", {7'b0, tx_valid}, 8'h00);
        check("flush_irq", {7'b0, irq}, 8'h01);
        for (int i = 0; i < 3; i++) wr_reg(3'd2, 8'(8'h70 + i));
        rdy = 1'b1;
        tick(); check_all();
        rst = 1'b0;
        tick(); check_all();
        check("rst_valid", {7'b0, tx_valid}, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_out_data", out_data, 8'h00);
        rst = 1'b1; rdy = 1'b0;
        tick(); check_all();
        rd(3'd0, 8'h01, "rst_status");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            rst  = ($urandom_range(199) != 0);
            cs   = ($urandom_range(3) == 0);
            wr   = $urandom_range(1);
            addr = ($urandom_range(1) != 0) ? 3'd2 : 3'($urandom_range(7));
            din  = 8'($urandom);
            if (addr == 3'd0 && din[4] && $urandom_range(7) != 0) din[4] = 1'b0;
            rdy  = ($urandom_range(2) == 0);
            tick();
            check_all();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
